// File: rtl/urisc_pkg.sv
// Shared urisc definitions: bus widths, output-port address and memory-responder states.
package urisc_pkg;
  localparam int URISC_AW = 8;
  localparam int URISC_DW = 8;
  localparam logic [URISC_AW-1:0] URISC_OUT_ADDR = 8'hFF;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/urisc_out_fifo.sv
// Synchronous FIFO for the memory-mapped output port; DEPTH must be a power of 2.
module urisc_out_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/urisc_mem_responder.sv
// urisc memory side: RAM with combinational read, byte-stream loader holding the CPU
// in reset, and an output port at OUT_ADDR feeding a valid/ready FIFO.
module urisc_mem_responder
  import urisc_pkg::*;
#(
  parameter int              AW         = URISC_AW,
  parameter int              DW         = URISC_DW,
  parameter logic [AW-1:0]   OUT_ADDR   = URISC_OUT_ADDR,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          overflow
);
  logic [DW-1:0] mem [2**AW];
  state_t        state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic          ld_xfer;
  logic          cpu_ram_we;
  logic          cpu_out_we;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  assign ld_ready   = (state_q == ST_LOAD) && !reset;
  assign ld_xfer    = ld_valid && ld_ready;
  assign cpu_ram_we = (state_q == ST_RUN) && !reset && cpu_we && (cpu_addr != OUT_ADDR);
  assign cpu_out_we = (state_q == ST_RUN) && !reset && cpu_we && (cpu_addr == OUT_ADDR);
  assign cpu_rdata  = mem[cpu_addr];
  assign out_valid  = !fifo_empty;
  assign fifo_pop   = out_valid && out_ready;

  // RAM has no reset: the loaded image must survive a CPU restart.
  always_ff @(posedge clk) begin
    if (ld_xfer)         mem[ld_ptr_q] <= ld_data;
    else if (cpu_ram_we) mem[cpu_addr] <= cpu_wdata;
  end

  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_xfer) begin
          ld_ptr_d = ld_ptr_q + AW'(1);
          if (ld_last || (ld_ptr_q == '1)) state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      ld_ptr_q  <= '0;
      cpu_reset <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_ptr_q  <= ld_ptr_d;
      cpu_reset <= (state_d == ST_LOAD);
      if (cpu_out_we && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  urisc_out_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_out_we),
    .wdata (cpu_wdata),
    .pop   (fifo_pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_urisc_mem_responder.sv
// Directed bench for urisc_mem_responder: load, RUN writes, output FIFO and reset.
module tb_urisc_mem_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  urisc_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_reset (cpu_reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
    cpu_addr = a;
    #1;
    chk(tag, cpu_rdata, exp);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    step();
    cpu_we    = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_ld_ready_in_reset", ld_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    #1;
    chk("rst_ld_ready", ld_ready, 1);

    // 1: three-byte image with a one-cycle gap
    ld_valid = 1'b1; ld_data = 8'h03; step();
    ld_valid = 1'b0; step();
    chk("t1_gap_cpu_reset", cpu_reset, 1);
    ld_valid = 1'b1; ld_data = 8'h05; step();
    ld_data = 8'h07; ld_last = 1'b1;
    #1;
    chk("t1_ready_before_last", ld_ready, 1);
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("t1_ld_ready_fell", ld_ready, 0);
    chk("t1_cpu_reset_fell", cpu_reset, 0);
    rd(8'h00, "t1_mem0", 8'h03);
    rd(8'h01, "t1_mem1", 8'h05);
    rd(8'h02, "t1_mem2", 8'h07);

    // 2: full 256-byte image, no ld_last; exit on pointer wrap
    reset = 1'b1; step(); reset = 1'b0;
    chk("t2_cpu_reset_after_rst", cpu_reset, 1);
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i) ^ 8'h5A;
      step();
      if (i == 254) chk("t2_still_loading_254", cpu_reset, 1);
    end
    chk("t2_cpu_reset_fell", cpu_reset, 0);
    chk("t2_ld_ready_fell", ld_ready, 0);
    ld_data = 8'hEE;
    step();
    step();
    ld_valid = 1'b0;
    rd(8'h00, "t2_mem0_unchanged", 8'h5A);
    rd(8'h01, "t2_mem1", 8'h5B);
    rd(8'hFF, "t2_memff", 8'hA5);
    rd(8'h10, "t2_mem10", 8'h4A);

    // 3: RAM write, read-during-write returns old data
    cpu_addr = 8'h10; cpu_wdata = 8'h99; cpu_we = 1'b1;
    #1;
    chk("t3_rdw_old", cpu_rdata, 8'h4A);
    step();
    cpu_we = 1'b0;
    rd(8'h10, "t3_new", 8'h99);

    // 4: output port write, no bypass
    cpu_addr = 8'hFF; cpu_wdata = 8'h41; cpu_we = 1'b1;
    #1;
    chk("t4_no_bypass", out_valid, 0);
    step();
    cpu_we = 1'b0;
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_data", out_data, 8'h41);
    rd(8'hFF, "t4_memff_unchanged", 8'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_popped", out_valid, 0);

    // 5a: full + push + pop in one cycle
    for (int k = 1; k <= 4; k++) cpu_write(8'hFF, 8'(k));
    chk("t5a_head", out_data, 8'h01);
    chk("t5a_no_ovf_full", overflow, 0);
    out_ready = 1'b1;
    cpu_write(8'hFF, 8'h05);
    chk("t5a_no_ovf_pushpop", overflow, 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("t5a_drain_valid_%0d", k), out_valid, 1);
      chk($sformatf("t5a_drain_data_%0d", k), out_data, 8'(k));
      step();
    end
    chk("t5a_empty", out_valid, 0);
    out_ready = 1'b0;

    // 5b: overflow on fifth push without pop
    for (int k = 1; k <= 4; k++) cpu_write(8'hFF, 8'(k));
    chk("t5b_no_ovf_at_4", overflow, 0);
    cpu_write(8'hFF, 8'h05);
    chk("t5b_ovf_at_5", overflow, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t5b_drain_data_%0d", k), out_data, 8'(k));
      step();
    end
    out_ready = 1'b0;
    chk("t5b_empty", out_valid, 0);
    chk("t5b_ovf_sticky", overflow, 1);
    rd(8'hFF, "t5_memff_unchanged", 8'hA5);

    // 6: reset mid-run with two entries queued
    cpu_write(8'hFF, 8'hA1);
    cpu_write(8'hFF, 8'hA2);
    chk("t6_queued", out_valid, 1);
    reset = 1'b1;
    step();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_cpu_reset", cpu_reset, 1);
    reset = 1'b0;
    #1;
    chk("t6_ld_ready", ld_ready, 1);
    rd(8'h10, "t6_mem10_kept", 8'h99);
    rd(8'h00, "t6_mem0_kept", 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
